ex_mem: RTL and testbench

Pipeline register between the execute stage and the memory stage of the five-stage 32-bit core. On each rising clock edge it captures the execute stage's write-back results: destination register, write enable, data, and HI/LO values. It presents them to the memory stage for the next cycle. It also honours the pipeline stall and flush controls, and holds the intermediate 64-bit accumulation state used by the two-cycle multiply-accumulate/subtract (MADD/MSUB) sequence in execute.

---
 rtl/ex_mem_pkg.sv | 29 ++
 rtl/ex_mem_acc.sv | 37 +++
 rtl/ex_mem.sv | 74 +++++++
 tb/tb_ex_mem.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared core definitions: bus widths, control constants and the EX->MEM write-back bundle.
// No logic; imported by the ex_mem pipeline register and its accumulator.
package ex_mem_pkg;

  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegBus;
  typedef logic [63:0] DoubleRegBus;

  localparam RegBus     ZeroWord     = 32'h0000_0000;
  localparam RegAddrBus NOPRegAddr   = 5'b00000;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      RstEnable    = 1'b1;
  localparam logic      Stop         = 1'b1;
  localparam logic      NoStop       = 1'b0;

  typedef struct packed {
    RegAddrBus wd;
    logic      wreg;
    RegBus     wdata;
    RegBus     hi;
    RegBus     lo;
    logic      whilo;
  } wb_t;

  localparam wb_t WbNop = '{wd: NOPRegAddr, wreg: WriteDisable, wdata: ZeroWord,
                            hi: ZeroWord, lo: ZeroWord, whilo: WriteDisable};

endpackage

// File: rtl/ex_mem_acc.sv
// MADD/MSUB partial-product holder: one-cycle capture on an execute-only stall, held on a full stall,
// cleared on reset, flush or when execute advances.
import ex_mem_pkg::*;

module ex_mem_acc (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_stall_ex,
  input  logic        i_stall_mem,
  input  DoubleRegBus i_hilo,
  input  logic [1:0]  i_cnt,
  output DoubleRegBus o_hilo,
  output logic [1:0]  o_cnt
);

  DoubleRegBus r_hilo;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst == RstEnable || i_flush) begin
      r_hilo <= '0;
      r_cnt  <= 2'b00;
    end else if (i_stall_ex == Stop && i_stall_mem == NoStop) begin
      r_hilo <= i_hilo;
      r_cnt  <= i_cnt;
    end else if (i_stall_ex == NoStop) begin
      // Execute consumed the partial product this cycle, so the sequence is finished.
      r_hilo <= '0;
      r_cnt  <= 2'b00;
    end
  end

  assign o_hilo = r_hilo;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/ex_mem.sv
// EX->MEM pipeline register, 1-cycle latency; stall_ex alone inserts a NOP bubble, both stalls hold, flush = reset.
// MADD/MSUB accumulation storage only when EX_MEM_MADD_EN is defined; otherwise hilo_o/cnt_o are tied to zero.
import ex_mem_pkg::*;

module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_ex,
  input  logic        stall_mem,
  input  RegAddrBus   ex_wd,
  input  logic        ex_wreg,
  input  RegBus       ex_wdata,
  input  RegBus       ex_hi,
  input  RegBus       ex_lo,
  input  logic        ex_whilo,
  input  DoubleRegBus hilo_i,
  input  logic [1:0]  cnt_i,
  output RegAddrBus   mem_wd,
  output logic        mem_wreg,
  output RegBus       mem_wdata,
  output RegBus       mem_hi,
  output RegBus       mem_lo,
  output logic        mem_whilo,
  output DoubleRegBus hilo_o,
  output logic [1:0]  cnt_o
);

  wb_t w_ex;
  wb_t r_wb;

  assign w_ex = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata,
                  hi: ex_hi, lo: ex_lo, whilo: ex_whilo};

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_wb <= WbNop;
    end else if (flush) begin
      r_wb <= WbNop;
    end else if (stall_ex == Stop && stall_mem == NoStop) begin
      r_wb <= WbNop;
    end else if (stall_ex == NoStop) begin
      // stall_mem cannot be the limiting stall while execute advances.
      r_wb <= w_ex;
    end
  end

  assign mem_wd    = r_wb.wd;
  assign mem_wreg  = r_wb.wreg;
  assign mem_wdata = r_wb.wdata;
  assign mem_hi    = r_wb.hi;
  assign mem_lo    = r_wb.lo;
  assign mem_whilo = r_wb.whilo;

`ifdef EX_MEM_MADD_EN
  ex_mem_acc u_acc (
    .clk         (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_stall_ex  (stall_ex),
    .i_stall_mem (stall_mem),
    .i_hilo      (hilo_i),
    .i_cnt       (cnt_i),
    .o_hilo      (hilo_o),
    .o_cnt       (cnt_o)
  );
`else
  logic w_unused_acc;
  assign w_unused_acc = ^{hilo_i, cnt_i};
  assign hilo_o = '0;
  assign cnt_o  = 2'b00;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed-vector bench for ex_mem: driver pushes hand-computed expectations, a monitor pops and compares each cycle.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        stall_ex = 1'b0;
  logic        stall_mem = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic        ex_whilo = 1'b0;
  logic [63:0] hilo_i = '0;
  logic [1:0]  cnt_i = '0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  ex_mem dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } obs_t;

  typedef struct {
    obs_t  o;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Accumulator outputs only carry data when the MADD storage is built in.
  function automatic logic [63:0] ah(input logic [63:0] v);
`ifdef EX_MEM_MADD_EN
    return v;
`else
    return 64'd0 & v;
`endif
  endfunction

  function automatic logic [1:0] ac(input logic [1:0] v);
`ifdef EX_MEM_MADD_EN
    return v;
`else
    return 2'b00 & v;
`endif
  endfunction

  function automatic obs_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                              input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                              input logic [63:0] hl, input logic [1:0] cn);
    obs_t o;
    o.wd = wd; o.wreg = wreg; o.wdata = wdata; o.hi = hi; o.lo = lo; o.whilo = whilo;
    o.hilo = hl; o.cnt = cn;
    return o;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what must appear after the next rising edge.
  task automatic vec(input string nm, input logic r, input logic f, input logic se, input logic sm,
                     input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                     input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                     input logic [63:0] hl, input logic [1:0] cn, input obs_t e);
    exp_t x;
    @(negedge clk);
    rst = r; flush = f; stall_ex = se; stall_mem = sm;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
    hilo_i = hl; cnt_i = cn;
    x.o = e; x.nm = nm;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  x;
      obs_t  got;
      x = exp_q.pop_front();
      got = mk(mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o);
      checks++;
      if (got !== x.o) begin
        errors++;
        $display("FAIL %s got wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%b exp wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%b",
                 x.nm, got.wd, got.wreg, got.wdata, got.hi, got.lo, got.whilo, got.hilo, got.cnt,
                 x.o.wd, x.o.wreg, x.o.wdata, x.o.hi, x.o.lo, x.o.whilo, x.o.hilo, x.o.cnt);
      end
    end
  end

  localparam logic [63:0] PROD = 64'h0000_0001_0000_0002;
  obs_t z;

  initial begin
    z = mk(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'b00);
    //   name         rst flush sex smem wd   wreg wdata          hi     lo     whilo hilo_i      cnt_i  expected
    vec("rst1",       1, 0, 0, 0, 5'd7, 1, 32'hDEADBEEF, 32'h1, 32'h2, 1, 64'h0, 2'b00, z);
    vec("rst2",       1, 0, 0, 0, 5'd7, 1, 32'hDEADBEEF, 32'h1, 32'h2, 1, 64'h0, 2'b00, z);
    vec("pass",       0, 0, 0, 0, 5'd3, 1, 32'h12345678, 32'hA, 32'hB, 1, 64'h0, 2'b00,
        mk(5'd3, 1, 32'h12345678, 32'hA, 32'hB, 1, 64'h0, 2'b00));
    vec("bubble",     0, 0, 1, 0, 5'd8, 1, 32'h77, 32'h3, 32'h4, 1, 64'h0, 2'b00, z);
    vec("load55",     0, 0, 0, 0, 5'd4, 1, 32'h55, 32'hC, 32'hD, 0, 64'h0, 2'b00,
        mk(5'd4, 1, 32'h55, 32'hC, 32'hD, 0, 64'h0, 2'b00));
    for (int i = 0; i < 3; i++)
      vec($sformatf("hold%0d", i), 0, 0, 1, 1, 5'd9, 1, 32'h99, 32'hE, 32'hF, 1, 64'hFF, 2'b11,
          mk(5'd4, 1, 32'h55, 32'hC, 32'hD, 0, 64'h0, 2'b00));
    vec("adv_smem",   0, 0, 0, 1, 5'd9, 1, 32'h99, 32'hE, 32'hF, 1, 64'hFF, 2'b11,
        mk(5'd9, 1, 32'h99, 32'hE, 32'hF, 1, 64'h0, 2'b00));
    vec("madd1",      0, 0, 1, 0, 5'd2, 1, 32'hAA, 32'h5, 32'h6, 1, PROD, 2'b01,
        mk(5'd0, 0, 32'h0, 32'h0, 32'h0, 0, ah(PROD), ac(2'b01)));
    vec("madd_hold",  0, 0, 1, 1, 5'd2, 1, 32'hAB, 32'h5, 32'h6, 1, 64'h5, 2'b10,
        mk(5'd0, 0, 32'h0, 32'h0, 32'h0, 0, ah(PROD), ac(2'b01)));
    vec("madd2",      0, 0, 0, 0, 5'd5, 1, 32'h1234, 32'h11, 32'h22, 1, 64'h0, 2'b00,
        mk(5'd5, 1, 32'h1234, 32'h11, 32'h22, 1, 64'h0, 2'b00));
    vec("madd1b",     0, 0, 1, 0, 5'd2, 1, 32'hAA, 32'h5, 32'h6, 1, PROD, 2'b01,
        mk(5'd0, 0, 32'h0, 32'h0, 32'h0, 0, ah(PROD), ac(2'b01)));
    vec("flush",      0, 1, 1, 0, 5'd2, 1, 32'hAA, 32'h5, 32'h6, 1, PROD, 2'b01, z);
    vec("post_flush", 0, 0, 0, 0, 5'd6, 0, 32'hC, 32'h1, 32'h2, 0, 64'h0, 2'b00,
        mk(5'd6, 0, 32'hC, 32'h1, 32'h2, 0, 64'h0, 2'b00));
    vec("madd1c",     0, 0, 1, 0, 5'd2, 1, 32'hAA, 32'h5, 32'h6, 1, PROD, 2'b01,
        mk(5'd0, 0, 32'h0, 32'h0, 32'h0, 0, ah(PROD), ac(2'b01)));
    vec("rst_mid",    1, 0, 1, 1, 5'd2, 1, 32'hAA, 32'h5, 32'h6, 1, PROD, 2'b01, z);
    vec("flush_hold", 0, 1, 1, 1, 5'd1, 1, 32'hBB, 32'h7, 32'h8, 1, PROD, 2'b01, z);
    vec("final",      0, 0, 0, 0, 5'd31, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 64'h0, 2'b00,
        mk(5'd31, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 64'h0, 2'b00));
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
